pipe_sum: RTL and testbench
===========================

// Module: pipe_sum
// PURPOSE
//  Parametrised pipelined adder/subtractor; next generation of the 32-bit ripple adder.
//  Splits a WIDTH-bit add/sub into STAGES equal carry-chained slices, one slice per cycle.
//  Carries the slice carry and skews operands through registers; sustains one op per cycle.
//  Sits between operand producers and result consumers with valid/ready on both sides.
// PARAMETERS
//  BUS_WIDTH  32  operand/result width in bits; must be a multiple of STAGES
//  STAGES     4   pipeline depth = latency in cycles; 1..BUS_WIDTH; slice = BUS_WIDTH/STAGES
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          asynchronous, active-high reset
//  sum_in_valid     in   1          operands/mode/carry-in valid this cycle
//  sum_in_ready     out  1          block accepts operands this cycle
//  sum_in1          in   BUS_WIDTH  operand A
//  sum_in2          in   BUS_WIDTH  operand B
//  sum_sub          in   1          0: A+B+cin, 1: A-B (A + ~B + 1; cin ignored)
//  sum_cin          in   1          carry-in, used only when sum_sub=0
//  sum_out_valid    out  1          result valid
//  sum_out_ready    in   1          consumer accepts result
//  sum_out          out  BUS_WIDTH  result, modulo 2^BUS_WIDTH
//  sum_nextbit_out  out  1          carry out of MSB (sub: 1 = no borrow)
//  sum_ovf_out      out  1          signed overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits, sum_out, sum_nextbit_out, sum_ovf_out = 0;
//    sum_in_ready = 1 after release; in-flight ops discarded, none emitted after reset.
//  - Advance enable: en = !sum_out_valid | sum_out_ready. Whole pipe shifts when en=1.
//  - sum_in_ready = en (combinational from sum_out_ready and output valid).
//  - Accept: sum_in_valid & sum_in_ready captures operands, mode, cin into stage 0.
//  - Stage k (0..STAGES-1) adds slice k (bits [k*S +: S], S=BUS_WIDTH/STAGES) of A and
//    B' (B' = sub ? ~B : B) plus incoming carry (stage 0: sub ? 1 : cin; else prior stage).
//  - Upper unprocessed slices of A/B' and lower finished result slices ride along in regs.
//  - Latency: op accepted at cycle t appears on outputs at t+STAGES when never stalled.
//  - Throughput: 1 op/cycle when sum_out_ready held 1.
//  - Stall: sum_out_valid=1 & sum_out_ready=0 freezes all stages; outputs stable until taken.
//  - Bubbles (invalid slots) shift with the pipe; no bubble collapsing.
//  - Simultaneous output take and input accept in same cycle is legal and lossless.
//  - sum_in_valid=1 while sum_in_ready=0: inputs ignored; producer must hold them.
//  - sum_out/flags change only on an enabled shift; registered, no comb path from inputs.
//  - STAGES=1: single-cycle registered adder, same handshake.
//  - Ops complete in order; carry between slices is exact (result equals full-width add).
// TESTING
//  1 add, W=32,S=4: A=0xFFFFFFFF,B=0x1,cin=0 -> sum=0x0,carry=1,ovf=0 after 4 cycles.
//  2 sub: A=0x5,B=0x7 -> sum=0xFFFFFFFE,carry=0 (borrow),ovf=0; A=0x80000000,B=1 -> ovf=1.
//  3 back-to-back: 8 ops on consecutive cycles, out_ready=1 -> 8 results consecutive,
//    in order, first at cycle 4.
//  4 stall: hold out_ready=0 with pipe full -> in_ready=0, outputs frozen; release ->
//    all results delivered once, none lost or duplicated.
//  5 reset mid-flight: 3 ops inside, assert rst -> valid=0 immediately, no stale output.
//  6 random sweep W in {8,32,64}, S in {1,2,W/4}: compare against A+B'+c reference model.

Source files
------------

// File: rtl/pipe_sum.sv
// Pipelined carry-chained adder/subtractor with valid/ready on both sides.
// Each stage resolves one BUS_WIDTH/STAGES slice; the whole pipe stalls as one.
module pipe_sum #(
    parameter int BUS_WIDTH = 32,
    parameter int STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sum_in_valid,
    output logic                 sum_in_ready,
    input  logic [BUS_WIDTH-1:0] sum_in1,
    input  logic [BUS_WIDTH-1:0] sum_in2,
    input  logic                 sum_sub,
    input  logic                 sum_cin,
    output logic                 sum_out_valid,
    input  logic                 sum_out_ready,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic                 sum_nextbit_out,
    output logic                 sum_ovf_out
);

    localparam int S = BUS_WIDTH / STAGES;
    localparam int L = STAGES - 1;

    logic [BUS_WIDTH-1:0] a_q [STAGES];
    logic [BUS_WIDTH-1:0] a_d [STAGES];
    logic [BUS_WIDTH-1:0] b_q [STAGES];
    logic [BUS_WIDTH-1:0] b_d [STAGES];
    logic [BUS_WIDTH-1:0] r_q [STAGES];
    logic [BUS_WIDTH-1:0] r_d [STAGES];
    logic [STAGES-1:0]    cy_q;
    logic [STAGES-1:0]    cy_d;
    logic [STAGES-1:0]    vld_q;
    logic [STAGES-1:0]    vld_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic                 en;
    logic [BUS_WIDTH-1:0] a_in;
    logic [BUS_WIDTH-1:0] b_in;
    logic [BUS_WIDTH-1:0] r_in;
    logic                 c_in;
    logic                 v_in;
    logic [S:0]           slice;

    assign en           = ~vld_q[L] | sum_out_ready;
    assign sum_in_ready = en;

    always_comb begin
        a_d   = '{default: '0};
        b_d   = '{default: '0};
        r_d   = '{default: '0};
        cy_d  = '0;
        vld_d = '0;
        a_in  = '0;
        b_in  = '0;
        r_in  = '0;
        c_in  = 1'b0;
        v_in  = 1'b0;
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction is A + ~B + 1, so the incoming carry becomes 1.
                a_in = sum_in1;
                b_in = sum_sub ? ~sum_in2 : sum_in2;
                r_in = '0;
                c_in = sum_sub | sum_cin;
                v_in = sum_in_valid;
            end else begin
                a_in = a_q[(k + L) % STAGES];
                b_in = b_q[(k + L) % STAGES];
                r_in = r_q[(k + L) % STAGES];
                c_in = cy_q[(k + L) % STAGES];
                v_in = vld_q[(k + L) % STAGES];
            end
            slice = {1'b0, a_in[k*S +: S]}
                  + {1'b0, b_in[k*S +: S]}
                  + {{S{1'b0}}, c_in};
            a_d[k]          = a_in;
            b_d[k]          = b_in;
            r_d[k]          = r_in;
            r_d[k][k*S +: S] = slice[S-1:0];
            cy_d[k]         = slice[S];
            vld_d[k]        = v_in;
        end
        // a^b^sum at the MSB recovers the carry into the MSB.
        ovf_d = a_d[L][BUS_WIDTH-1] ^ b_d[L][BUS_WIDTH-1]
              ^ r_d[L][BUS_WIDTH-1] ^ cy_d[L];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            r_q   <= '{default: '0};
            cy_q  <= '0;
            vld_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            cy_q  <= cy_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_out_valid   = vld_q[L];
    assign sum_out         = r_q[L];
    assign sum_nextbit_out = cy_q[L];
    assign sum_ovf_out     = ovf_q;

endmodule

// File: tb/tb_pipe_sum.sv
// Scoreboard bench for pipe_sum: directed 32/4 scenarios plus a
// random sweep over several width/depth configurations.
module tb_pipe_sum;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int NSW = 8;
    localparam int CW [NSW] = '{8, 8, 32, 32, 32, 64, 64, 64};
    localparam int CS [NSW] = '{1, 2, 1, 2, 8, 1, 2, 16};

    typedef logic [33:0] res_t;
    typedef struct { res_t e; int t; } sb_t;
    typedef struct {
        res_t got;
        res_t e;
        int   lat;
        int   at;
        bit   orphan;
    } obs_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        bit          c;
        res_t        e;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          cout;
    logic          ovf;

    logic [63:0]   sw_a  [NSW];
    logic [63:0]   sw_b  [NSW];
    logic [63:0]   sw_o  [NSW];
    logic          sw_v  [NSW];
    logic          sw_ir [NSW];
    logic          sw_s  [NSW];
    logic          sw_c  [NSW];
    logic          sw_ov [NSW];
    logic          sw_or [NSW];
    logic          sw_co [NSW];
    logic          sw_vf [NSW];
    logic [65:0]   sw_sb [NSW][$];

    sb_t  sb_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   acc;
    bit   took;
    bit   timed_out;

    always #5 clk = ~clk;

    pipe_sum #(.BUS_WIDTH(W), .STAGES(ST)) dut (
        .clk            (clk),
        .rst            (rst),
        .sum_in_valid   (in_valid),
        .sum_in_ready   (in_ready),
        .sum_in1        (a),
        .sum_in2        (b),
        .sum_sub        (sub),
        .sum_cin        (cin),
        .sum_out_valid  (out_valid),
        .sum_out_ready  (out_ready),
        .sum_out        (out),
        .sum_nextbit_out(cout),
        .sum_ovf_out    (ovf)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int GW = CW[g];
        localparam int GS = CS[g];
        logic [GW-1:0] o_w;
        pipe_sum #(.BUS_WIDTH(GW), .STAGES(GS)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .sum_in_valid   (sw_v[g]),
            .sum_in_ready   (sw_ir[g]),
            .sum_in1        (sw_a[g][GW-1:0]),
            .sum_in2        (sw_b[g][GW-1:0]),
            .sum_sub        (sw_s[g]),
            .sum_cin        (sw_c[g]),
            .sum_out_valid  (sw_ov[g]),
            .sum_out_ready  (sw_or[g]),
            .sum_out        (o_w),
            .sum_nextbit_out(sw_co[g]),
            .sum_ovf_out    (sw_vf[g])
        );
        assign sw_o[g] = 64'(o_w);
    end

    function automatic logic [63:0] wmask(int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: {ovf, carry, sum} of a full-width a + b' + c.
    function automatic logic [65:0] model(int w, logic [63:0] x,
                                          logic [63:0] y, logic s, logic c);
        logic [63:0] m;
        logic [63:0] bp;
        logic [64:0] f;
        logic        sa;
        logic        sb;
        logic        sr;
        m  = wmask(w);
        bp = (s ? ~y : y) & m;
        f  = {1'b0, x & m} + {1'b0, bp} + {64'd0, (s | c)};
        sa = x[w-1];
        sb = bp[w-1];
        sr = f[w-1];
        return {(sa == sb) && (sr != sa), f[w], f[63:0] & m};
    endfunction

    function automatic op_t mkop(logic [31:0] x, logic [31:0] y,
                                 bit s, bit c, res_t e);
        op_t o;
        o.a = x;
        o.b = y;
        o.s = s;
        o.c = c;
        o.e = e;
        return o;
    endfunction

    function automatic op_t rop();
        op_t         o;
        logic [65:0] r;
        o.a = $urandom;
        o.b = $urandom;
        o.s = 1'($urandom_range(0, 1));
        o.c = 1'($urandom_range(0, 1));
        r   = model(32, {32'd0, o.a}, {32'd0, o.b}, o.s, o.c);
        o.e = {r[65], r[64], r[31:0]};
        return o;
    endfunction

    task automatic cycle(input bit v, input logic [31:0] aa,
                         input logic [31:0] bb, input bit s, input bit c,
                         input bit rdy, input res_t e);
        sb_t  p;
        obs_t o;
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        sub       = s;
        cin       = c;
        out_ready = rdy;
        #1;
        acc  = v && in_ready;
        took = out_valid && out_ready;
        if (took) begin
            o.got    = {ovf, cout, out};
            o.at     = cyc;
            o.orphan = (sb_q.size() == 0);
            o.e      = '0;
            o.lat    = -1;
            if (!o.orphan) begin
                p     = sb_q.pop_front();
                o.e   = p.e;
                o.lat = cyc - p.t;
            end
            obs_q.push_back(o);
        end
        if (acc) begin
            p.e = e;
            p.t = cyc;
            sb_q.push_back(p);
        end
        cyc++;
    endtask

    task automatic run_ops(input op_t ops[$], input int rdy_from,
                           input int budget);
        int i = 0;
        obs_q.delete();
        timed_out = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (i < ops.size())
                cycle(1'b1, ops[i].a, ops[i].b, ops[i].s, ops[i].c,
                      n >= rdy_from, ops[i].e);
            else
                cycle(1'b0, '0, '0, 1'b0, 1'b0, n >= rdy_from, '0);
            if (acc) i++;
            if (i == ops.size() && sb_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out !== '0) begin
            n_bad++;
            $display("FAIL reset sum: got %h want 0", out);
        end
        n_cmp++;
        if (cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset carry: got %b want 0", cout);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset ovf: got %b want 0", ovf);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        op_t ops[$];
        ops.push_back(mkop(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
                           {1'b0, 1'b1, 32'h0000_0000}));
        ops.push_back(mkop(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1,
                           {1'b1, 1'b0, 32'h8000_0000}));
        ops.push_back(mkop(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                           {1'b0, 1'b0, 32'h2345_6789}));
        ops.push_back(mkop(32'h0000_FFFF, 32'h1, 1'b0, 1'b0,
                           {1'b0, 1'b0, 32'h0001_0000}));
        ops.push_back(mkop(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                           {1'b1, 1'b1, 32'h0000_0000}));
        run_ops(ops, 0, 40);
        n_cmp++;
        if (timed_out) begin
            n_bad++;
            $display("FAIL add drain: got timeout want all %0d", ops.size());
        end
        n_cmp++;
        if (obs_q.size() != ops.size()) begin
            n_bad++;
            $display("FAIL add count: got %0d want %0d",
                     obs_q.size(), ops.size());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i].orphan || obs_q[i].got !== obs_q[i].e) begin
                n_bad++;
                $display("FAIL add[%0d]: got %h want %h",
                         i, obs_q[i].got, obs_q[i].e);
            end
            n_cmp++;
            if (obs_q[i].lat != ST) begin
                n_bad++;
                $display("FAIL add latency[%0d]: got %0d want %0d",
                         i, obs_q[i].lat, ST);
            end
        end
    endtask

    task automatic test_sub();
        op_t ops[$];
        ops.push_back(mkop(32'h5, 32'h7, 1'b1, 1'b0,
                           {1'b0, 1'b0, 32'hFFFF_FFFE}));
        ops.push_back(mkop(32'h8000_0000, 32'h1, 1'b1, 1'b0,
                           {1'b1, 1'b1, 32'h7FFF_FFFF}));
        ops.push_back(mkop(32'h5, 32'h5, 1'b1, 1'b1,
                           {1'b0, 1'b1, 32'h0000_0000}));
        ops.push_back(mkop(32'h0, 32'h1, 1'b1, 1'b0,
                           {1'b0, 1'b0, 32'hFFFF_FFFF}));
        ops.push_back(mkop(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
                           {1'b1, 1'b0, 32'h8000_0000}));
        run_ops(ops, 0, 40);
        n_cmp++;
        if (timed_out) begin
            n_bad++;
            $display("FAIL sub drain: got timeout want all %0d", ops.size());
        end
        n_cmp++;
        if (obs_q.size() != ops.size()) begin
            n_bad++;
            $display("FAIL sub count: got %0d want %0d",
                     obs_q.size(), ops.size());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i].orphan || obs_q[i].got !== obs_q[i].e) begin
                n_bad++;
                $display("FAIL sub[%0d]: got %h want %h",
                         i, obs_q[i].got, obs_q[i].e);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        int  t0;
        for (int k = 0; k < 8; k++) ops.push_back(rop());
        t0 = cyc;
        run_ops(ops, 0, 40);
        n_cmp++;
        if (timed_out || obs_q.size() != 8) begin
            n_bad++;
            $display("FAIL b2b count: got %0d want 8", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0].at - t0 != ST) begin
                n_bad++;
                $display("FAIL b2b first: got cycle %0d want %0d",
                         obs_q[0].at - t0, ST);
            end
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i].orphan || obs_q[i].got !== obs_q[i].e) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h want %h",
                         i, obs_q[i].got, obs_q[i].e);
            end
            n_cmp++;
            if (obs_q[i].at != obs_q[0].at + i) begin
                n_bad++;
                $display("FAIL b2b gap[%0d]: got cycle %0d want %0d",
                         i, obs_q[i].at, obs_q[0].at + i);
            end
        end
    endtask

    task automatic test_stall();
        op_t ops[$];
        int  i = 0;
        bit  done = 1'b0;
        for (int k = 0; k < 6; k++) ops.push_back(rop());
        obs_q.delete();
        for (int n = 0; n < 60 && !done; n++) begin
            if (i < 6)
                cycle(1'b1, ops[i].a, ops[i].b, ops[i].s, ops[i].c,
                      n >= 10, ops[i].e);
            else
                cycle(1'b0, '0, '0, 1'b0, 1'b0, n >= 10, '0);
            if (acc) i++;
            if (n == 6 || n == 9) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall in_ready@%0d: got %b want 0",
                             n, in_ready);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || {ovf, cout, out} !== ops[0].e) begin
                    n_bad++;
                    $display("FAIL stall hold@%0d: got %b/%h want 1/%h",
                             n, out_valid, {ovf, cout, out}, ops[0].e);
                end
            end
            if (n == 9) begin
                n_cmp++;
                if (obs_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL stall early take: got %0d want 0",
                             obs_q.size());
                end
            end
            done = (i == 6) && (sb_q.size() == 0);
        end
        n_cmp++;
        if (!done || obs_q.size() != 6) begin
            n_bad++;
            $display("FAIL stall delivered: got %0d want 6", obs_q.size());
        end
        foreach (obs_q[k]) begin
            n_cmp++;
            if (obs_q[k].orphan || obs_q[k].got !== obs_q[k].e) begin
                n_bad++;
                $display("FAIL stall[%0d]: got %h want %h",
                         k, obs_q[k].got, obs_q[k].e);
            end
        end
    endtask

    task automatic test_reset_midflight();
        op_t ops[$];
        op_t post[$];
        for (int k = 0; k < 3; k++) ops.push_back(rop());
        obs_q.delete();
        sb_q.delete();
        for (int n = 0; n < 5; n++) begin
            if (n < 3)
                cycle(1'b1, ops[n].a, ops[n].b, ops[n].s, ops[n].c,
                      1'b0, ops[n].e);
            else
                cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, cout, out} !== ops[0].e) begin
            n_bad++;
            $display("FAIL mid pre-reset: got %b/%h want 1/%h",
                     out_valid, {ovf, cout, out}, ops[0].e);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid reset valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if ({ovf, cout, out} !== '0) begin
            n_bad++;
            $display("FAIL mid reset data: got %h want 0", {ovf, cout, out});
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid stale: got %0d outputs want 0", obs_q.size());
        end
        post.push_back(rop());
        run_ops(post, 0, 20);
        n_cmp++;
        if (timed_out || obs_q.size() != 1 || obs_q[0].got !== post[0].e) begin
            n_bad++;
            $display("FAIL mid post-reset op: got %0d results want %h",
                     obs_q.size(), post[0].e);
        end
    endtask

    task automatic test_random_sweep();
        bit          hold [NSW];
        logic [65:0] e;
        logic [65:0] got;
        int          ncyc = 400;
        for (int g = 0; g < NSW; g++) begin
            hold[g] = 1'b0;
            sw_sb[g].delete();
        end
        for (int n = 0; n < ncyc + 60; n++) begin
            @(negedge clk);
            for (int g = 0; g < NSW; g++) begin
                if (!hold[g]) begin
                    sw_v[g] = (n < ncyc) && ($urandom_range(0, 4) != 0);
                    sw_a[g] = ($urandom_range(0, 7) == 0) ? wmask(CW[g])
                            : {$urandom, $urandom} & wmask(CW[g]);
                    sw_b[g] = ($urandom_range(0, 7) == 0) ? 64'd1
                            : {$urandom, $urandom} & wmask(CW[g]);
                    sw_s[g] = 1'($urandom_range(0, 1));
                    sw_c[g] = 1'($urandom_range(0, 1));
                end
                sw_or[g] = (n >= ncyc) || ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int g = 0; g < NSW; g++) begin
                if (sw_ov[g] && sw_or[g]) begin
                    n_cmp++;
                    got = {sw_vf[g], sw_co[g], sw_o[g]};
                    if (sw_sb[g].size() == 0) begin
                        n_bad++;
                        $display("FAIL sweep W%0d S%0d: got %h want none",
                                 CW[g], CS[g], got);
                    end else begin
                        e = sw_sb[g].pop_front();
                        if (got !== e) begin
                            n_bad++;
                            $display("FAIL sweep W%0d S%0d: got %h want %h",
                                     CW[g], CS[g], got, e);
                        end
                    end
                end
                if (sw_v[g] && sw_ir[g]) begin
                    sw_sb[g].push_back(model(CW[g], sw_a[g], sw_b[g],
                                             sw_s[g], sw_c[g]));
                    hold[g] = 1'b0;
                end else begin
                    hold[g] = sw_v[g];
                end
            end
        end
        for (int g = 0; g < NSW; g++) begin
            n_cmp++;
            if (sw_sb[g].size() != 0 || hold[g]) begin
                n_bad++;
                $display("FAIL sweep W%0d S%0d lost: got %0d pending want 0",
                         CW[g], CS[g], sw_sb[g].size());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < NSW; g++) begin
            sw_v[g]  = 1'b0;
            sw_or[g] = 1'b0;
            sw_a[g]  = '0;
            sw_b[g]  = '0;
            sw_s[g]  = 1'b0;
            sw_c[g]  = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
